// File: rtl/teclado_pkg.sv
// Shared constants and sizing helpers for the kcpsm3 keypad event peripheral.
// Holds the default port map, the processor data width and counter sizing functions.
package teclado_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] PORT_EVT_DEF = 8'h01;
    localparam logic [DATA_W-1:0] PORT_LVL_DEF = 8'h02;

    localparam int               N_BTN_DEF      = 4;
    localparam int               DEB_CYCLES_DEF = 500000;
    localparam logic [DATA_W-1:0] REP_EN_DEF    = 8'h03;
    localparam int               REP_DELAY_DEF  = 25000000;
    localparam int               REP_PERIOD_DEF = 5000000;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_EVT  = 2'd1,
        SEL_LVL  = 2'd2
    } rd_sel_e;

    // Bits needed to hold the values 0 .. v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/teclado_eventos_pb_if.sv
// kcpsm3 input-bus view of the keypad peripheral: port read plus level interrupt.
// master is the processor side, slave is the peripheral side.
interface teclado_eventos_pb_if;
    import teclado_pkg::*;

    logic [DATA_W-1:0] port_id;
    logic              read_strobe;
    logic [DATA_W-1:0] in_port;
    logic              interrupt;
    logic              interrupt_ack;

    modport master (
        output port_id,
        output read_strobe,
        output interrupt_ack,
        input  in_port,
        input  interrupt
    );

    modport slave (
        input  port_id,
        input  read_strobe,
        input  interrupt_ack,
        output in_port,
        output interrupt
    );

endinterface

// File: rtl/teclado_eventos_pb_debounce_canal.sv
// One button channel: two-flop synchroniser, debounce counter, press edge detect
// and optional auto-repeat generator. press_pulse is a registered one-cycle pulse.
module debounce_canal
    import teclado_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter bit REP_ENABLE = 1'b0,
    parameter int REP_DELAY  = REP_DELAY_DEF,
    parameter int REP_PERIOD = REP_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press_pulse
);

    localparam int CW    = clog2(DEB_CYCLES);
    localparam int RW_RAW = clog2(max2(REP_DELAY, REP_PERIOD));
    localparam int RW    = (RW_RAW < 1) ? 1 : RW_RAW;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rcnt;
    logic          rep_run;

    logic          accept;
    logic          rise;
    logic          stable_nxt;
    logic          rep_fire;

    // rep_run selects the first-repeat delay versus the steady repeat period.
    always_comb begin
        accept     = (sync_p1 != stable) && (cnt == DEB_LAST);
        rise       = accept && sync_p1;
        stable_nxt = accept ? sync_p1 : stable;
        rep_fire   = REP_ENABLE && stable && stable_nxt &&
                     (rcnt == (rep_run ? PER_LAST : DLY_LAST));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0     <= 1'b0;
            sync_p1     <= 1'b0;
            cnt         <= '0;
            stable      <= 1'b0;
            press_pulse <= 1'b0;
            rcnt        <= '0;
            rep_run     <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;

            if (sync_p1 != stable) begin
                cnt <= accept ? '0 : cnt + 1'b1;
            end else begin
                cnt <= '0;
            end

            stable      <= stable_nxt;
            press_pulse <= rise | rep_fire;

            // Release (seen through stable_nxt) clears the repeat timer on the same edge.
            if (!REP_ENABLE || !stable_nxt || rise) begin
                rcnt    <= '0;
                rep_run <= 1'b0;
            end else if (rep_fire) begin
                rcnt    <= '0;
                rep_run <= 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/teclado_eventos_pb.sv
// Keypad event peripheral for the kcpsm3 input bus: per-button debounce channels,
// clear-on-read event latch, registered read mux and level interrupt.
module teclado_eventos_pb
    import teclado_pkg::*;
#(
    parameter int               N_BTN      = N_BTN_DEF,
    parameter int               DEB_CYCLES = DEB_CYCLES_DEF,
    parameter logic [DATA_W-1:0] REP_EN    = REP_EN_DEF,
    parameter int               REP_DELAY  = REP_DELAY_DEF,
    parameter int               REP_PERIOD = REP_PERIOD_DEF,
    parameter logic [DATA_W-1:0] PORT_EVT  = PORT_EVT_DEF,
    parameter logic [DATA_W-1:0] PORT_LVL  = PORT_LVL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    teclado_eventos_pb_if.slave bus
);

    logic [N_BTN-1:0]  stable;
    logic [N_BTN-1:0]  set;
    logic [N_BTN-1:0]  evt;
    logic [N_BTN-1:0]  clr_mask;
    rd_sel_e           rd_sel;
    logic [DATA_W-1:0] evt_ext;
    logic [DATA_W-1:0] lvl_ext;
    logic [DATA_W-1:0] rd_data;

    for (genvar i = 0; i < N_BTN; i++) begin : g_canal
        debounce_canal #(
            .DEB_CYCLES (DEB_CYCLES),
            .REP_ENABLE (REP_EN[i]),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
        ) u_canal (
            .clk         (clk),
            .reset       (reset),
            .raw         (btn[i]),
            .stable      (stable[i]),
            .press_pulse (set[i])
        );
    end

    // Clear uses the value already on in_port, so only reported bits are dropped.
    always_comb begin
        rd_sel = SEL_NONE;
        if (bus.port_id == PORT_EVT) begin
            rd_sel = SEL_EVT;
        end else if (bus.port_id == PORT_LVL) begin
            rd_sel = SEL_LVL;
        end

        evt_ext              = '0;
        evt_ext[N_BTN-1:0]   = evt;
        lvl_ext              = '0;
        lvl_ext[N_BTN-1:0]   = stable;

        case (rd_sel)
            SEL_EVT: rd_data = evt_ext;
            SEL_LVL: rd_data = lvl_ext;
            default: rd_data = '0;
        endcase

        clr_mask = '0;
        if (bus.read_strobe && (rd_sel == SEL_EVT)) begin
            clr_mask = bus.in_port[N_BTN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt           <= '0;
            bus.in_port   <= '0;
            bus.interrupt <= 1'b0;
        end else begin
            evt         <= (evt & ~clr_mask) | set;
            bus.in_port <= rd_data;
            if (set != '0) begin
                bus.interrupt <= 1'b1;
            end else if (bus.interrupt_ack) begin
                bus.interrupt <= 1'b0;
            end
        end
    end

endmodule
